rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//   Shares the register file's single write port (WE3/A3/WD3) between two writers:
//   - the pipeline write-back stage
//   - the multi-cycle unit (divider/multiplier) that returns results late
//   Keeps a pending-write scoreboard so hazard logic can stall readers of registers still in flight.
//   Sits between the WB stage, the multi-cycle unit and RegFiles.
// PARAMETERS
//   FIFO_DEPTH    4   mc result buffer entries; power of 2, >=2
//   STARVE_LIMIT  8   consecutive blocked-drain cycles before wb_stall is forced; >=1
// PORTS
//   clk            in   1   single clock; all state updates on posedge
//   rst_n          in   1   asynchronous, active-low reset
//   wb_we          in   1   pipeline write-back request
//   wb_addr        in   5   pipeline destination register
//   wb_data        in   32  pipeline write data
//   wb_stall       out  1   registered; pipeline must hold its WB instruction this cycle
//   mc_issue       in   1   pulse: multi-cycle op issued, reserve mc_issue_addr
//   mc_issue_addr  in   5   destination of the issued op
//   mc_valid       in   1   multi-cycle result valid
//   mc_addr        in   5   result destination
//   mc_data        in   32  result data
//   mc_ready       out  1   result accepted when mc_valid&&mc_ready
//   rd_addr1       in   5   ID-stage source 1, scoreboard lookup
//   rd_addr2       in   5   ID-stage source 2
//   busy1          out  1   pending[rd_addr1], combinational
//   busy2          out  1   pending[rd_addr2], combinational
//   rf_we          out  1   to RegFiles WE3
//   rf_waddr       out  5   to RegFiles A3
//   rf_wdata       out  32  to RegFiles WD3
//   err_dbl_issue  out  1   sticky: mc_issue hit an already pending register
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - FIFO empty, pending=0, starve counter=0, FSM=IDLE
//     - wb_stall=0, err_dbl_issue=0; rf_we=0, mc_ready=1 once released
//   Write port (combinational, latency 0), priority order:
//     1. wb_stall=1: wb_we ignored. Drain FIFO head.
//     2. wb_we && wb_addr!=0: rf_we=1, rf_waddr=wb_addr, rf_wdata=wb_data.
//     3. FIFO non-empty: rf_we=1 with the head entry. Pop at posedge.
//     4. Otherwise: rf_we=0; rf_waddr and rf_wdata are don't-care (drive 0).
//   wb_we with wb_addr=0 counts as no request, so the FIFO may drain.
//   mc handshake:
//     - mc_ready = (count<FIFO_DEPTH), from registered count; no combinational path from mc_valid.
//     - Accepted result is pushed at posedge. Minimum latency to rf_we is 1 cycle; no same-cycle bypass.
//     - Accepted result with mc_addr=0: dropped, not pushed.
//     - Push and pop in the same cycle: count unchanged, order preserved.
//   Scoreboard (32-bit pending):
//     - mc_issue && mc_issue_addr!=0: set bit.
//     - FIFO pop: clear bit of the popped address.
//     - Same cycle, same addr, set and clear: set wins.
//     - mc_issue on a set bit: err_dbl_issue<=1 (sticky until reset); the bit stays set.
//     - pending[0] is always 0.
//   Pipeline must not write a pending register; if it does, the later drain overwrites it (no check).
//   FSM {IDLE, BLOCKED, FORCE}:
//     IDLE    -> BLOCKED: FIFO non-empty and wb write wins
//     BLOCKED: count++ each cycle drain is blocked
//       -> IDLE: drain happens or FIFO empty; counter=0
//       -> FORCE: count reaches STARVE_LIMIT
//     FORCE: wb_stall=1 for exactly one cycle, one entry drained, counter=0
//       -> IDLE: FIFO empty
//       -> BLOCKED: FIFO still non-empty
//   Reset mid-operation: buffered results and reservations are discarded; the mc unit is reset alongside.
// STRUCTURE
//   Package rf_arb_pkg:
//     - REG_AW=5, REG_DW=32, REG_ZERO=5'd0
//     - FSM state encoding {IDLE, BLOCKED, FORCE}
//     - FIFO entry struct {addr, data}
//   Sub-module rf_arb_fifo:
//     - synchronous FIFO, depth FIFO_DEPTH
//     - ports: push, pop, head, count, full, empty; async active-low reset
//   Arbitration mux, scoreboard and FSM live in this module.
// TESTING
//   1. Reset, then mc_issue r5, mc result r5=0xDEADBEEF, wb idle.
//      -> busy on r5 from the cycle after issue; rf_we r5 one cycle after accept; busy1(r5)=0 after the pop.
//   2. wb_we r3=0x11 in the same cycle as a FIFO head r7=0x22.
//      -> r3 written first; r7 written the next idle cycle.
//   3. Push 4 results with no drain.
//      -> mc_ready=0 after the 4th accept; 5th held until one pop.
//   4. wb_we every cycle, 1 entry buffered.
//      -> wb_stall=1 exactly once, after 8 blocked cycles; entry drained in that cycle.
//   5. mc result to r0; and mc_issue r9 twice.
//      -> r0: no push, no rf_we. r9: err_dbl_issue=1 and stays 1 until rst_n.
//   6. rst_n low with 2 entries and 3 pending bits.
//      -> immediately rf_we=0, busy=0, count=0; mc_ready=1 after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Used by rf_arb_fifo and rf_write_arbiter.
package rf_arb_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLOCKED,
        ST_FORCE
    } arb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Synchronous FIFO holding multi-cycle results until the write port is free.
// The head entry is visible combinationally; pop advances it at posedge.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fifo_entry_t            push_entry,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; count and pointers alone define validity,
    // so stale entries are never observed and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between write-back and a
// multi-cycle unit, tracking in-flight destinations for hazard detection.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [REG_DW-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mc_issue,
    input  logic [REG_AW-1:0] mc_issue_addr,
    input  logic              mc_valid,
    input  logic [REG_AW-1:0] mc_addr,
    input  logic [REG_DW-1:0] mc_data,
    output logic              mc_ready,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [REG_DW-1:0] rf_wdata,
    output logic              err_dbl_issue
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_M1 = SW'(STARVE_LIMIT - 1);

    fifo_entry_t   fifo_head;
    fifo_entry_t   push_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_en;
    logic          pop;
    logic          wb_req;
    logic          issue_en;
    logic          blocked;
    logic          going_empty;

    arb_state_e    state;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pending;
    logic [31:0]   pending_next;

    // mc_ready depends only on registered occupancy, never on mc_valid.
    assign mc_ready   = !fifo_full;
    assign push_en    = mc_valid && mc_ready && (mc_addr != REG_ZERO);
    assign push_entry = '{addr: mc_addr, data: mc_data};
    assign wb_req     = wb_we && (wb_addr != REG_ZERO);
    assign issue_en   = mc_issue && (mc_issue_addr != REG_ZERO);

    rf_arb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_en),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the if-chain can leave a value held and infer a latch.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_ZERO;
        rf_wdata = '0;
        pop      = 1'b0;
        if (wb_stall) begin
            if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_waddr = fifo_head.addr;
                rf_wdata = fifo_head.data;
                pop      = 1'b1;
            end
        end else if (wb_req) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end else if (!fifo_empty) begin
            rf_we    = 1'b1;
            rf_waddr = fifo_head.addr;
            rf_wdata = fifo_head.data;
            pop      = 1'b1;
        end
    end

    assign blocked     = !fifo_empty && !pop;
    assign going_empty = (fifo_count == CW'(1)) && !push_en;

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        pending_next = pending;
        if (pop) begin
            pending_next[fifo_head.addr] = 1'b0;
        end
        if (issue_en) begin
            pending_next[mc_issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            err_dbl_issue <= 1'b0;
        end else begin
            pending <= pending_next;
            if (issue_en && pending[mc_issue_addr]) begin
                err_dbl_issue <= 1'b1;
            end
        end
    end

    assign busy1 = pending[rd_addr1];
    assign busy2 = pending[rd_addr2];

    // starve_cnt holds the number of consecutive blocked drain cycles seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_BLOCKED: begin
                    if (blocked) begin
                        if (starve_cnt >= LIMIT_M1) begin
                            state      <= ST_FORCE;
                            starve_cnt <= '0;
                            wb_stall   <= 1'b1;
                        end else begin
                            state      <= ST_BLOCKED;
                            starve_cnt <= starve_cnt + 1'b1;
                            wb_stall   <= 1'b0;
                        end
                    end else begin
                        state      <= ST_IDLE;
                        starve_cnt <= '0;
                        wb_stall   <= 1'b0;
                    end
                end
                ST_FORCE: begin
                    state      <= going_empty ? ST_IDLE : ST_BLOCKED;
                    starve_cnt <= '0;
                    wb_stall   <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    starve_cnt <= '0;
                    wb_stall   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: drain latency, priority, backpressure,
// starvation override, r0 handling, double-issue error and async reset.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        wb_stall;
    logic        mc_issue = 1'b0;
    logic [4:0]  mc_issue_addr = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_addr = '0;
    logic [31:0] mc_data = '0;
    logic        mc_ready;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        busy1;
    logic        busy2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err_dbl_issue;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_stall      (wb_stall),
        .mc_issue      (mc_issue),
        .mc_issue_addr (mc_issue_addr),
        .mc_valid      (mc_valid),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .mc_ready      (mc_ready),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .busy1         (busy1),
        .busy2         (busy2),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .err_dbl_issue (err_dbl_issue)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
        checks++;
        if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall got=%0b exp=0", wb_stall); end
        checks++;
        if (err_dbl_issue !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err_dbl_issue); end
        checks++;
        if (mc_ready !== 1'b1) begin errors++; $display("FAIL reset_mc_ready got=%0b exp=1", mc_ready); end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%0b exp=0", busy1); end
        tick();
    endtask

    task automatic test_issue_drain();
        rd_addr1 = 5'd5;
        mc_issue = 1'b1; mc_issue_addr = 5'd5;
        settle();
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL t1_busy_issue_cycle got=%0b exp=0", busy1); end
        tick();
        mc_issue = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'hDEADBEEF;
        settle();
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL t1_busy_after_issue got=%0b exp=1", busy1); end
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL t1_no_bypass got=%0b exp=0", rf_we); end
        tick();
        mc_valid = 1'b0;
        settle();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL t1_drain got we=%0b a=%0d d=%h exp we=1 a=5 d=deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (busy1 !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL t1_after_pop got busy1=%0b we=%0b exp 0 0", busy1, rf_we);
        end
    endtask

    task automatic test_priority();
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h22;
        tick();
        mc_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        settle();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
            errors++;
            $display("FAIL t2_wb_first got we=%0b a=%0d d=%h exp we=1 a=3 d=11", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        wb_we = 1'b0;
        settle();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22) begin
            errors++;
            $display("FAIL t2_fifo_next got we=%0b a=%0d d=%h exp we=1 a=7 d=22", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL t2_idle got=%0b exp=0", rf_we); end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_addr;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
        for (int i = 0; i < 4; i++) begin
            mc_valid = 1'b1; mc_addr = 5'(10 + i); mc_data = 32'h100 + 32'(10 + i);
            tick();
        end
        mc_addr = 5'd14; mc_data = 32'h10E;
        settle();
        checks++;
        if (mc_ready !== 1'b0) begin errors++; $display("FAIL t3_full_ready got=%0b exp=0", mc_ready); end
        tick();
        checks++;
        if (mc_ready !== 1'b0) begin errors++; $display("FAIL t3_held_ready got=%0b exp=0", mc_ready); end
        tick();
        wb_we = 1'b0;
        settle();
        checks++;
        if (mc_ready !== 1'b0 || rf_waddr !== 5'd10) begin
            errors++;
            $display("FAIL t3_first_pop got ready=%0b a=%0d exp ready=0 a=10", mc_ready, rf_waddr);
        end
        tick();
        checks++;
        if (mc_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_after_pop got=%0b exp=1", mc_ready); end
        for (int i = 1; i < 5; i++) begin
            exp_addr = 5'(10 + i);
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== exp_addr || rf_wdata !== 32'h100 + 32'(exp_addr)) begin
                errors++;
                $display("FAIL t3_order[%0d] got we=%0b a=%0d d=%h exp a=%0d", i, rf_we, rf_waddr, rf_wdata, exp_addr);
            end
            tick();
            mc_valid = 1'b0;
            settle();
        end
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL t3_empty got=%0b exp=0", rf_we); end
        tick();
    endtask

    task automatic test_starvation();
        int stall_cnt = 0;
        int stall_idx = -1;
        mc_valid = 1'b1; mc_addr = 5'd20; mc_data = 32'h4040;
        tick();
        mc_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hAAAA;
        for (int i = 0; i < 14; i++) begin
            settle();
            checks++;
            if (wb_stall === 1'b1) begin
                stall_cnt++;
                if (stall_idx < 0) stall_idx = i;
                if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'h4040) begin
                    errors++;
                    $display("FAIL t4_forced_drain[%0d] got we=%0b a=%0d d=%h exp a=20 d=4040", i, rf_we, rf_waddr, rf_wdata);
                end
            end else if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin
                errors++;
                $display("FAIL t4_wb_wins[%0d] got we=%0b a=%0d exp we=1 a=1", i, rf_we, rf_waddr);
            end
            tick();
        end
        wb_we = 1'b0;
        checks++;
        if (stall_cnt != 1 || stall_idx != 8) begin
            errors++;
            $display("FAIL t4_stall_count got cnt=%0d idx=%0d exp cnt=1 idx=8", stall_cnt, stall_idx);
        end
        settle();
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL t4_drained got=%0b exp=0", rf_we); end
        tick();
    endtask

    task automatic test_r0_and_dbl_issue();
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hBAD;
        settle();
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL t5_r0_same got=%0b exp=0", rf_we); end
        tick();
        mc_valid = 1'b0;
        settle();
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL t5_r0_dropped got=%0b exp=0", rf_we); end
        mc_valid = 1'b1; mc_addr = 5'd23; mc_data = 32'h55;
        tick();
        mc_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h77;
        settle();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd23 || rf_wdata !== 32'h55) begin
            errors++;
            $display("FAIL t5_wb_r0_drain got we=%0b a=%0d d=%h exp a=23 d=55", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        wb_we = 1'b0;
        rd_addr1 = 5'd9;
        mc_issue = 1'b1; mc_issue_addr = 5'd9;
        tick();
        settle();
        checks++;
        if (err_dbl_issue !== 1'b0) begin errors++; $display("FAIL t5_err_early got=%0b exp=0", err_dbl_issue); end
        tick();
        mc_issue = 1'b0;
        settle();
        checks++;
        if (err_dbl_issue !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL t5_err_set got err=%0b busy=%0b exp 1 1", err_dbl_issue, busy1);
        end
        repeat (3) tick();
        checks++;
        if (err_dbl_issue !== 1'b1) begin errors++; $display("FAIL t5_err_sticky got=%0b exp=1", err_dbl_issue); end
    endtask

    task automatic test_reset_midop();
        rd_addr1 = 5'd9; rd_addr2 = 5'd21;
        mc_issue = 1'b1; mc_issue_addr = 5'd21;
        tick();
        mc_issue_addr = 5'd22;
        tick();
        mc_issue = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd1;
        mc_valid = 1'b1; mc_addr = 5'd21; mc_data = 32'h21;
        tick();
        mc_addr = 5'd22; mc_data = 32'h22;
        tick();
        mc_valid = 1'b0;
        settle();
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL t6_pre_busy got b1=%0b b2=%0b exp 1 1", busy1, busy2);
        end
        wb_we = 1'b0;
        rst_n = 1'b0;
        settle();
        checks++;
        if (rf_we !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0 || err_dbl_issue !== 1'b0) begin
            errors++;
            $display("FAIL t6_in_reset got we=%0b b1=%0b b2=%0b err=%0b exp all 0", rf_we, busy1, busy2, err_dbl_issue);
        end
        tick();
        rst_n = 1'b1;
        settle();
        checks++;
        if (mc_ready !== 1'b1 || rf_we !== 1'b0 || wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL t6_released got ready=%0b we=%0b stall=%0b exp 1 0 0", mc_ready, rf_we, wb_stall);
        end
        tick();
        rd_addr1 = 5'd22;
        settle();
        checks++;
        if (rf_we !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL t6_discarded got we=%0b busy=%0b exp 0 0", rf_we, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_issue_drain();
        test_priority();
        test_backpressure();
        test_starvation();
        test_r0_and_dbl_issue();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
